// File: rtl/htif_host.sv
// htif_host: host-side responder for the tohost/fromhost mailbox.
// Decodes each nonzero tohost word as an exit request, a console putchar,
// or a bad command, streams putchar bytes over valid/ready and acks every
// non-exit command through a one-cycle fromhost write.
// Optional feature macro: HTIF_CHAR_COUNT_EN builds a 32-bit counter of
// delivered characters; without it char_count is tied to zero.
module htif_host #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tohost_wr_en,
    input  logic [31:0] tohost_wdata,
    output logic        busy,
    output logic        fromhost_wr_en,
    output logic [31:0] fromhost_wdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        exit_valid,
    output logic [30:0] exit_code,
    output logic        err,
    output logic [31:0] char_count
);

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, DECODE, SEND, ACK, HALT} state_t;

    state_t      state;
    logic [31:0] cmd;
    logic [15:0] tmo_cnt;
    logic        busy_st;

    assign busy_st = (state == DECODE) || (state == SEND) || (state == ACK);

    // Command FSM; every output is registered and changes with the state move.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cmd            <= '0;
            tmo_cnt        <= '0;
            busy           <= 1'b0;
            fromhost_wr_en <= 1'b0;
            fromhost_wdata <= '0;
            char_valid     <= 1'b0;
            char_data      <= '0;
            exit_valid     <= 1'b0;
            exit_code      <= '0;
            err            <= 1'b0;
        end else begin
            fromhost_wr_en <= 1'b0;
            // A write while a command is in flight is lost; flag it.
            if (tohost_wr_en && busy_st)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (tohost_wr_en && tohost_wdata != 32'h0) begin
                        cmd   <= tohost_wdata;
                        busy  <= 1'b1;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    // The console device/command tag is checked before the exit
                    // bit: printable bytes are routinely odd, so a putchar word
                    // often has bit 0 set and must not be taken as an exit.
                    if (cmd[31:24] == 8'h01 && cmd[23:16] == 8'h01) begin
                        char_data  <= cmd[7:0];
                        char_valid <= 1'b1;
                        tmo_cnt    <= TMO_LOAD;
                        state      <= SEND;
                    end else if (cmd[0]) begin
                        exit_code  <= cmd[31:1];
                        exit_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= HALT;
                    end else begin
                        err            <= 1'b1;
                        fromhost_wr_en <= 1'b1;
                        fromhost_wdata <= {cmd[31:16], 15'b0, 1'b0};
                        state          <= ACK;
                    end
                end
                SEND: begin
                    // char_valid is high throughout SEND, so ready alone completes it.
                    if (char_ready) begin
                        char_valid     <= 1'b0;
                        fromhost_wr_en <= 1'b1;
                        fromhost_wdata <= {cmd[31:16], 15'b0, 1'b1};
                        state          <= ACK;
                    end else if (tmo_cnt == 16'h0) begin
                        err            <= 1'b1;
                        char_valid     <= 1'b0;
                        fromhost_wr_en <= 1'b1;
                        fromhost_wdata <= {cmd[31:16], 15'b0, 1'b0};
                        state          <= ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt - 16'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HTIF_CHAR_COUNT_EN
    // Count completed character handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)
            char_count <= '0;
        else if (state == SEND && char_ready)
            char_count <= char_count + 32'd1;
    end
`else
    assign char_count = 32'h0;
`endif

endmodule

// File: tb/tb_htif_host.sv
// Testbench for htif_host: table of directed vectors, hand-written corner
// sequences and randomized commands checked against a transaction model.
module tb_htif_host;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        tohost_wr_en;
    logic [31:0] tohost_wdata;
    logic        busy;
    logic        fromhost_wr_en;
    logic [31:0] fromhost_wdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        exit_valid;
    logic [30:0] exit_code;
    logic        err;
    logic [31:0] char_count;

    htif_host #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .tohost_wr_en(tohost_wr_en), .tohost_wdata(tohost_wdata),
        .busy(busy),
        .fromhost_wr_en(fromhost_wr_en), .fromhost_wdata(fromhost_wdata),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .exit_valid(exit_valid), .exit_code(exit_code),
        .err(err), .char_count(char_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cmd;
        int          d;       // cycles of char_valid before ready is raised
        bit          is_exit;
        int          lat;     // cycles from write edge to ack (or exit_valid)
        logic [31:0] ack;
        bit          hs;
        logic [7:0]  ch;
        logic [30:0] code;
        bit          err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // model state carried across commands
    bit          m_err;
    logic [31:0] m_cc;

    // observations from run_cmd
    int          o_hs, o_acks, o_ack_lat, o_exit_lat;
    logic [7:0]  o_char;
    logic [31:0] o_ack;
    logic        o_busy1, o_busy_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tohost_wr_en = 1'b0; tohost_wdata = '0; char_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_err = 1'b0;
        m_cc  = '0;
    endtask

    // Transaction-level reference: what a command should do given ready delay d.
    function automatic vec_t model(input logic [31:0] c, input int d);
        vec_t v;
        v.cmd = c; v.d = d; v.is_exit = 1'b0; v.hs = 1'b0; v.ch = 8'h0;
        v.code = '0; v.err = 1'b0; v.ack = '0; v.lat = 0;
        if (c[31:16] == 16'h0101) begin
            v.ch = c[7:0];
            if (d < T) begin
                v.hs = 1'b1; v.lat = 3 + d; v.ack = {c[31:16], 16'h0001};
            end else begin
                v.err = 1'b1; v.lat = 2 + T; v.ack = {c[31:16], 16'h0000};
            end
        end else if (c[0]) begin
            v.is_exit = 1'b1; v.lat = 2; v.code = c[31:1];
        end else begin
            v.err = 1'b1; v.lat = 2; v.ack = {c[31:16], 16'h0000};
        end
        return v;
    endfunction

    // Issue one command and watch the bus until it resolves (bounded).
    task automatic run_cmd(input logic [31:0] c, input int d);
        int vcnt;
        vcnt = 0;
        o_hs = 0; o_acks = 0; o_ack_lat = -1; o_exit_lat = -1;
        o_char = '0; o_ack = '0; o_busy1 = 1'b0; o_busy_end = 1'b1;
        @(negedge clk);
        tohost_wr_en = 1'b1; tohost_wdata = c; char_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            tohost_wr_en = 1'b0;
            if (i == 1) o_busy1 = busy;
            if (char_valid) begin
                vcnt++;
                char_ready = (vcnt - 1 >= d);
                if (char_ready) begin o_hs++; o_char = char_data; end
            end else begin
                char_ready = 1'b0;
            end
            if (fromhost_wr_en) begin
                o_acks++; o_ack = fromhost_wdata;
                if (o_ack_lat < 0) o_ack_lat = i;
            end
            if (exit_valid && o_exit_lat < 0) o_exit_lat = i;
            if (o_ack_lat > 0 && i == o_ack_lat + 1) begin o_busy_end = busy; break; end
            if (o_exit_lat > 0 && i == o_exit_lat + 2) begin o_busy_end = busy; break; end
        end
        char_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] exp_cc;
        run_cmd(v.cmd, v.d);
        m_err = m_err | v.err;
        if (v.hs) m_cc = m_cc + 32'd1;
        check({tag, ".busy_n1"}, 32'(o_busy1), 32'd1);
        if (v.is_exit) begin
            check({tag, ".exit_lat"}, o_exit_lat, v.lat);
            check({tag, ".exit_code"}, 32'(exit_code), 32'(v.code));
            check({tag, ".no_ack"}, o_acks, 0);
        end else begin
            check({tag, ".ack_lat"}, o_ack_lat, v.lat);
            check({tag, ".ack_data"}, o_ack, v.ack);
            check({tag, ".ack_count"}, o_acks, 1);
            check({tag, ".handshakes"}, o_hs, 32'(v.hs));
            if (v.hs) check({tag, ".char"}, 32'(o_char), 32'(v.ch));
            check({tag, ".exit_valid"}, 32'(exit_valid), 32'd0);
        end
        check({tag, ".busy_end"}, 32'(o_busy_end), 32'd0);
        check({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef HTIF_CHAR_COUNT_EN
        exp_cc = m_cc;
`else
        exp_cc = 32'h0;
`endif
        check({tag, ".char_count"}, char_count, exp_cc);
    endtask

    vec_t tbl[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   cyc, acks;
        bit   seen;
        reset = 1'b1; tohost_wr_en = 1'b0; tohost_wdata = '0; char_ready = 1'b0;

        // cmd, d, is_exit, lat, ack, hs, ch, code, err
        tbl[0] = '{32'h0101_0041, 0, 1'b0, 3,     32'h0101_0001, 1'b1, 8'h41, 31'd0, 1'b0};
        tbl[1] = '{32'h0101_0042, 8, 1'b0, 2 + T, 32'h0101_0000, 1'b0, 8'h42, 31'd0, 1'b1};
        tbl[2] = '{32'h0101_0042, 7, 1'b0, 10,    32'h0101_0001, 1'b1, 8'h42, 31'd0, 1'b0};
        tbl[3] = '{32'h0200_0000, 0, 1'b0, 2,     32'h0200_0000, 1'b0, 8'h00, 31'd0, 1'b1};
        tbl[4] = '{32'h0000_0001, 0, 1'b1, 2,     32'h0,         1'b0, 8'h00, 31'd0, 1'b0};
        tbl[5] = '{32'h0000_0007, 0, 1'b1, 2,     32'h0,         1'b0, 8'h00, 31'd3, 1'b0};
        tbl[6] = '{32'h0101_00ff, 3, 1'b0, 6,     32'h0101_0001, 1'b1, 8'hff, 31'd0, 1'b0};
        tbl[7] = '{32'h0103_0010, 0, 1'b0, 2,     32'h0103_0000, 1'b0, 8'h00, 31'd0, 1'b1};

        // reset state
        do_reset();
        check("rst.busy", 32'(busy), 0);
        check("rst.char_valid", 32'(char_valid), 0);
        check("rst.char_data", 32'(char_data), 0);
        check("rst.fromhost_wr_en", 32'(fromhost_wr_en), 0);
        check("rst.fromhost_wdata", fromhost_wdata, 0);
        check("rst.exit_valid", 32'(exit_valid), 0);
        check("rst.exit_code", 32'(exit_code), 0);
        check("rst.err", 32'(err), 0);
        check("rst.char_count", char_count, 0);

        // write of zero is ignored without error
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h0;
        @(negedge clk); tohost_wr_en = 1'b0;
        check("zero.busy", 32'(busy), 0);
        @(negedge clk);
        check("zero.err", 32'(err), 0);
        check("zero.busy2", 32'(busy), 0);

        // directed table, fresh reset per vector
        for (int k = 0; k < 8; k++) begin
            do_reset();
            apply_vec(tbl[k], $sformatf("tbl%0d", k));
        end

        // exit pass then a later write is ignored in HALT
        do_reset();
        apply_vec(tbl[4], "halt");
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h5;
        @(negedge clk); tohost_wr_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check("halt.exit_code", 32'(exit_code), 0);
        check("halt.exit_valid", 32'(exit_valid), 1);
        check("halt.err", 32'(err), 0);
        check("halt.busy", 32'(busy), 0);

        // busy collision: second write one cycle later is dropped
        do_reset();
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h0101_0043; char_ready = 1'b1;
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h0000_0001;
        @(negedge clk); tohost_wr_en = 1'b0;
        check("coll.char_valid", 32'(char_valid), 1);
        check("coll.char_data", 32'(char_data), 32'h43);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fromhost_wr_en) begin
                seen = 1'b1;
                check("coll.ack_data", fromhost_wdata, 32'h0101_0001);
            end
        end
        char_ready = 1'b0;
        check("coll.ack_seen", 32'(seen), 1);
        check("coll.err", 32'(err), 1);
        @(negedge clk); @(negedge clk);
        check("coll.exit_valid", 32'(exit_valid), 0);
        check("coll.busy", 32'(busy), 0);

        // write landing in the ACK cycle is dropped and flagged
        do_reset();
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h0101_0045; char_ready = 1'b1;
        @(negedge clk); tohost_wr_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fromhost_wr_en) begin
                seen = 1'b1;
                tohost_wr_en = 1'b1; tohost_wdata = 32'h0000_0001;
            end
        end
        char_ready = 1'b0;
        check("ackw.ack_seen", 32'(seen), 1);
        @(negedge clk); tohost_wr_en = 1'b0;
        check("ackw.busy", 32'(busy), 0);
        check("ackw.err", 32'(err), 1);
        @(negedge clk); @(negedge clk);
        check("ackw.exit_valid", 32'(exit_valid), 0);
        check("ackw.busy2", 32'(busy), 0);

        // reset mid-SEND discards the byte, no ack follows
        do_reset();
        @(negedge clk); tohost_wr_en = 1'b1; tohost_wdata = 32'h0101_0044; char_ready = 1'b0;
        @(negedge clk); tohost_wr_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rsend.char_valid", 32'(char_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rsend.busy", 32'(busy), 0);
        check("rsend.char_valid0", 32'(char_valid), 0);
        check("rsend.char_data", 32'(char_data), 0);
        check("rsend.fromhost", {fromhost_wdata[31:1], fromhost_wr_en}, 0);
        check("rsend.err", 32'(err), 0);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fromhost_wr_en) acks++;
        end
        check("rsend.no_ack", acks, 0);

        // randomized commands against the model
        do_reset();
        for (int k = 0; k < 60; k++) begin
            logic [31:0] c;
            int cat, d;
            cat = $urandom_range(0, 2);
            d   = $urandom_range(0, T + 2);
            c   = $urandom;
            if (cat == 0) begin
                c[31:16] = 16'h0101;
            end else begin
                if (c[31:16] == 16'h0101) c[31] = 1'b1;
                if (cat == 1) c[0] = 1'b1;
                else begin
                    c[0] = 1'b0;
                    if (c == 32'h0) c = 32'h2;
                end
            end
            v = model(c, d);
            apply_vec(v, $sformatf("rnd%0d", k));
            if (v.is_exit) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
